// File: rtl/single_ram_ctrl_pkg.sv
// single_ram_ctrl_pkg: FSM state encoding and requester count shared by the RAM arbiter files
package single_ram_ctrl_pkg;
    localparam int NUM_REQ = 2;
    typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin pick; a tie goes to the requester that was not granted last
module rr_arbiter_2
    import single_ram_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);
    assign grant[0] = req_valid[0] & (~req_valid[1] | last_grant);
    assign grant[1] = req_valid[1] & (~req_valid[0] | ~last_grant);
endmodule

// File: rtl/single_ram.sv
// single_ram: one-port RAM with registered read, driving the shared data bus while cs & oe & !we
module single_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input logic                  clk,
    input logic                  cs,
    input logic                  we,
    input logic                  oe,
    input logic [ADDR_WIDTH-1:0] addr,
    inout wire  [DATA_WIDTH-1:0] data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_q;
    always_ff @(posedge clk) begin
        if (cs && we) mem[addr] <= data;
        if (cs && !we) rd_q <= mem[addr];
    end
    assign data = (cs && oe && !we) ? rd_q : 'z;
endmodule

// File: rtl/single_ram_arbiter.sv
// single_ram_arbiter: shares one single_ram port between two requesters with a round-robin
// arbiter and a write/read sequencing FSM; the only driver of the RAM control pins.
module single_ram_arbiter
    import single_ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_cs,
    output logic                          ram_we,
    output logic                          ram_oe,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    inout  wire  [DATA_WIDTH-1:0]         ram_data
);
    state_t                state;
    logic                  last_grant;
    logic                  gnt_q;
    logic [NUM_REQ-1:0]    grant;
    logic                  gidx;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [DATA_WIDTH-1:0] wdata_q;

    rr_arbiter_2 u_arb (
        .req_valid (req_valid),
        .last_grant(last_grant),
        .grant     (grant)
    );

    always_comb begin
        gidx      = grant[1];
        sel_we    = req_we[gidx];
        sel_addr  = gidx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        sel_wdata = gidx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        req_ready = (state == IDLE) ? grant : '0;
    end

    // ram_we is high only in WR, so it doubles as the bus-drive enable
    assign ram_data = ram_we ? wdata_q : 'z;

    // Pin values are registered on entry to each state so they line up with the state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt_q      <= 1'b0;
            wdata_q    <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            ram_cs     <= 1'b0;
            ram_we     <= 1'b0;
            ram_oe     <= 1'b0;
            ram_addr   <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: if (|grant) begin
                    state      <= sel_we ? WR : RD1;
                    last_grant <= gidx;
                    gnt_q      <= gidx;
                    wdata_q    <= sel_wdata;
                    ram_cs     <= 1'b1;
                    ram_we     <= sel_we;
                    ram_oe     <= ~sel_we;
                    ram_addr   <= sel_addr;
                end
                WR: begin
                    state            <= IDLE;
                    ram_cs           <= 1'b0;
                    ram_we           <= 1'b0;
                    rsp_valid[gnt_q] <= 1'b1;
                end
                RD1: state <= RD2;
                RD2: begin
                    state            <= IDLE;
                    ram_cs           <= 1'b0;
                    ram_oe           <= 1'b0;
                    rsp_rdata        <= ram_data;
                    rsp_valid[gnt_q] <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_single_ram_arbiter.sv
// tb_single_ram_arbiter: scoreboard bench for single_ram_arbiter driving a real single_ram
module tb_single_ram_arbiter;
    logic        clk = 0;
    logic        rstn = 0;
    logic        v0 = 0, v1 = 0, we0 = 0, we1 = 0;
    logic [3:0]  a0 = 0, a1 = 0;
    logic [15:0] d0 = 0, d1 = 0;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [15:0] rsp_rdata;
    logic        ram_cs, ram_we, ram_oe;
    logic [3:0]  ram_addr;
    wire  [15:0] ram_data;

    assign req_valid = {v1, v0};
    assign req_we    = {we1, we0};
    assign req_addr  = {a1, a0};
    assign req_wdata = {d1, d0};

    single_ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr), .ram_data(ram_data)
    );

    single_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) u_ram (
        .clk(clk), .cs(ram_cs), .we(ram_we), .oe(ram_oe), .addr(ram_addr), .data(ram_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          id;
        logic        we;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    logic [15:0] model_mem [16];
    logic [15:0] last_rd;
    logic        mlast;
    int          cs_from, cs_to;
    logic        cur_we, exp_cs;
    logic [3:0]  cur_addr;
    logic [15:0] cur_wdata;
    logic [1:0]  exp_ready;

    always @(posedge clk) cyc <= cyc + 1;

    initial for (int i = 0; i < 16; i++) model_mem[i] = '0;

    // Reference model: expected grant, pin window and response timing, checked every cycle
    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
            mlast   = 1'b1;
            cs_from = 0;
            cs_to   = -1;
            last_rd = '0;
        end else begin
            exp_cs = (cyc >= cs_from) && (cyc <= cs_to);
            check("ram_cs", 32'(ram_cs), 32'(exp_cs));
            check("ram_we", 32'(ram_we), 32'(exp_cs && cur_we));
            check("ram_oe", 32'(ram_oe), 32'(exp_cs && !cur_we));
            check("bus_conflict", 32'(ram_we && ram_oe), 0);
            if (exp_cs) check("ram_addr", 32'(ram_addr), 32'(cur_addr));
            if (exp_cs && cur_we) check("ram_data", 32'(ram_data), 32'(cur_wdata));
            check("rsp_onehot", 32'($countones(rsp_valid) <= 1), 1);
            check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            if (rsp_valid != 2'b00) begin
                if (sb.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 0);
                else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(rsp_valid), 32'(2'b01 << e.id));
                    check("rsp_latency", cyc, e.due);
                    if (!e.we) last_rd = e.data;
                    check(e.we ? "rsp_hold" : "rsp_rdata", 32'(rsp_rdata), 32'(last_rd));
                end
            end
            exp_ready[0] = !exp_cs && v0 && (!v1 || mlast);
            exp_ready[1] = !exp_cs && v1 && (!v0 || !mlast);
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            if (exp_ready != 2'b00) begin
                e.id      = exp_ready[1] ? 1 : 0;
                mlast     = exp_ready[1];
                cur_we    = exp_ready[1] ? we1 : we0;
                cur_addr  = exp_ready[1] ? a1 : a0;
                cur_wdata = exp_ready[1] ? d1 : d0;
                if (cur_we) model_mem[cur_addr] = cur_wdata;
                e.we   = cur_we;
                e.data = model_mem[cur_addr];
                e.due  = cyc + (cur_we ? 2 : 3);
                sb.push_back(e);
                cs_from = cyc + 1;
                cs_to   = cyc + (cur_we ? 1 : 2);
            end
        end
    end

    task automatic issue(input int id, input logic we, input logic [3:0] a, input logic [15:0] d);
        logic ok;
        ok = 1'b0;
        if (id == 0) begin we0 = we; a0 = a; d0 = d; v0 = 1'b1; end
        else begin we1 = we; a1 = a; d1 = d; v1 = 1'b1; end
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = req_ready[id];
        end
        if (!ok) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (id == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        check("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        // Reset mid-read: accept a read, enter RD1, then pull reset
        we0 = 1'b0; a0 = 4'h5; v0 = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 v0 = 1'b0;
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("rst_cs", 32'(ram_cs), 0);
        check("rst_we", 32'(ram_we), 0);
        check("rst_oe", 32'(ram_oe), 0);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rdata", 32'(rsp_rdata), 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_no_rsp", 32'(rsp_valid), 0);
        end
        rstn = 1'b1;
        // First tie after reset goes to requester 0
        fork
            issue(0, 1'b1, 4'h4, 16'h1111);
            issue(1, 1'b1, 4'h5, 16'h2222);
        join
        drain();
        // Single write then read
        issue(0, 1'b1, 4'h3, 16'hBEEF);
        issue(0, 1'b0, 4'h3, 16'h0000);
        drain();
        // Contention: both always valid, grants alternate
        fork
            for (int i = 0; i < 8; i++) issue(0, 1'b1, 4'(i), 16'h1000 + 16'(i));
            for (int i = 0; i < 8; i++) issue(1, 1'b1, 4'(i + 8), 16'h2000 + 16'(i));
        join
        drain();
        for (int i = 0; i < 16; i++) issue(0, 1'b0, 4'(i), 16'h0000);
        drain();
        // Hazard: last grant was requester 0, so the tie goes to requester 1's write
        fork
            issue(1, 1'b1, 4'hF, 16'hA5A5);
            issue(0, 1'b0, 4'hF, 16'h0000);
        join
        drain();
        // Boundaries and rdata hold across a later write response
        issue(0, 1'b1, 4'h0, 16'h0001);
        issue(1, 1'b1, 4'hF, 16'hFFFF);
        issue(0, 1'b0, 4'h0, 16'h0000);
        issue(1, 1'b0, 4'hF, 16'h0000);
        issue(0, 1'b1, 4'h7, 16'h1234);
        drain();
        check("final_hold", 32'(rsp_rdata), 32'h0000FFFF);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
